pipeid_hazard_sb: RTL and testbench
===================================

// Module: pipeid_hazard_sb
// PURPOSE
//  Parametrised ID-stage hazard/forwarding unit with an internal scoreboard.
//  Tracks the destinations of the DEPTH instructions in flight past ID (E,M,W,...).
//  Selects the forwarded operands for the rs/rt read ports and raises the load-use stall.
//  Sits between the register file read ports and the ID/EX register; replaces fixed 3-source fwd muxing.
// PARAMETERS
//  XLEN     32  datapath width
//  AW       5   register-number width (2**AW registers, r0 hard-wired zero)
//  DEPTH    3   tracked stages after ID; stage 0 = E, stage DEPTH-1 = last before RF write
//  LD_STAGE 1   first stage index where load data is valid (1 = M)
//  SW       2   select width, >= clog2(DEPTH+1)
// PORTS
//  clk        in  1           clock
//  clrn       in  1           async reset, active low
//  id_valid   in  1           ID holds a real instruction
//  id_rs      in  AW          source A reg no.
//  id_rt      in  AW          source B reg no.
//  id_use_rs  in  1           instruction reads rs
//  id_use_rt  in  1           instruction reads rt
//  id_wreg    in  1           instruction writes a register
//  id_rn      in  AW          destination reg no.
//  id_m2reg   in  1           instruction is a load
//  flush      in  1           squash the ID instruction (taken branch/jump)
//  rf_qa      in  XLEN        RF read data for rs
//  rf_qb      in  XLEN        RF read data for rt
//  stage_res  in  DEPTH*XLEN  result held by stage k at bits [k*XLEN +: XLEN]; for k>=LD_STAGE already m2reg-muxed
//  a          out XLEN        forwarded operand A
//  b          out XLEN        forwarded operand B
//  fwda       out SW          0 = RF, k+1 = stage k
//  fwdb       out SW          same for B
//  nostall    out 1           0 = hold PC and IF/ID, insert bubble
// BEHAVIOUR
//  - Scoreboard: DEPTH entries {v, wreg, rn, ld}; shifts every clk (entry k -> k+1; entry DEPTH-1 drops).
//  - Entry 0 loads {id_valid & nostall & ~flush, id_wreg, id_rn, id_m2reg}; stall or flush inserts bubble (v=0).
//  - Reset (clrn=0, async): all entries v=0; hence nostall=1, fwda=fwdb=0, a=rf_qa, b=rf_qb.
//  - Match for a source s: used & s!=0 & entry v & wreg & rn==s. Youngest (lowest k) match wins.
//  - No match -> select 0 (RF). Match at k -> select k+1, data = stage_res[k].
//  - Load-use: winning match has ld=1 and k<LD_STAGE -> nostall=0 (older matches ignored).
//  - nostall, fwda/b, a, b combinational from scoreboard + ID inputs; zero-cycle latency.
//  - flush does not affect nostall; it only blocks the insert into entry 0.
//  - id_valid=0 -> no stall, selects still computed but don't-care.
//  - rn==0 entries never match (writes to r0 are discarded).
//  - Same rn in several entries: youngest supplies data; stall evaluated on youngest only.
//  - Reset mid-operation clears all entries; the first post-reset instruction never forwards.
// CONFIGURATION
//  PIPEID_SB_STATS_EN defined: adds outputs stall_cnt[31:0], fwd_cnt[31:0].
//    stall_cnt +1 per clk with id_valid & ~nostall; fwd_cnt +1 per clk with
//    id_valid & nostall & (fwda!=0 | fwdb!=0); both saturate at 32'hFFFF_FFFF; reset to 0.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING  (DEPTH=3, LD_STAGE=1)
//  ALU dep: add r3 issued, next cycle id_rs=3 -> fwda=1, a=stage_res[0]=32'h1234, nostall=1.
//  Distance 3: r5 written, two unrelated instrs, then id_rt=5 -> fwdb=3, b=stage_res[2].
//  Load-use: lw r4 issued, next id_rs=4 -> nostall=0 one cycle; bubble enters; retry gives fwda=2, nostall=1.
//  Youngest wins: r7 at k=2 and k=0, id_rs=id_rt=7 -> fwda=fwdb=1.
//  r0 / flush: dest r0 -> fwda=0; flush with id_rn=9 -> later id_rs=9 gives fwda=0.
//  Reset: clrn low mid-stream with r2 pending -> after release id_rs=2 gives fwda=0, a=rf_qa; stats (if EN) = 0.

Source files
------------

// File: rtl/pipeid_hazard_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeid_hazard_sb : ID-stage operand forwarding and load-use stall, driven   |
// | by a shift-register scoreboard of in-flight destinations.                   |
// | Optional macro PIPEID_SB_STATS_EN adds stall_cnt / fwd_cnt outputs.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipeid_hazard_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LD_STAGE = 1,
  parameter int SW       = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_rs,
  input  logic [AW-1:0]         id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wreg,
  input  logic [AW-1:0]         id_rn,
  input  logic                  id_m2reg,
  input  logic                  flush,
  input  logic [XLEN-1:0]       rf_qa,
  input  logic [XLEN-1:0]       rf_qb,
  input  logic [DEPTH*XLEN-1:0] stage_res,
  output logic [XLEN-1:0]       a,
  output logic [XLEN-1:0]       b,
  output logic [SW-1:0]         fwda,
  output logic [SW-1:0]         fwdb,
`ifdef PIPEID_SB_STATS_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           fwd_cnt,
`endif
  output logic                  nostall
);

  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0]         wreg_q, wreg_d;
  logic [DEPTH-1:0]         ld_q, ld_d;
  logic [DEPTH-1:0][AW-1:0] rn_q, rn_d;
  logic                     stall_a;
  logic                     stall_b;

  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    fwda    = '0;
    a       = rf_qa;
    stall_a = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_use_rs && (id_rs != '0) && v_q[k] && wreg_q[k] && (rn_q[k] == id_rs)) begin
        fwda    = SW'(k + 1);
        a       = stage_res[k*XLEN +: XLEN];
        stall_a = ld_q[k] && (k < LD_STAGE);
      end
    end
  end

  always_comb begin
    fwdb    = '0;
    b       = rf_qb;
    stall_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_use_rt && (id_rt != '0) && v_q[k] && wreg_q[k] && (rn_q[k] == id_rt)) begin
        fwdb    = SW'(k + 1);
        b       = stage_res[k*XLEN +: XLEN];
        stall_b = ld_q[k] && (k < LD_STAGE);
      end
    end
  end

  assign nostall = ~(id_valid & (stall_a | stall_b));

  always_comb begin
    v_d[0]    = id_valid & nostall & ~flush;
    wreg_d[0] = id_wreg;
    rn_d[0]   = id_rn;
    ld_d[0]   = id_m2reg;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      wreg_d[k] = wreg_q[k-1];
      rn_d[k]   = rn_q[k-1];
      ld_d[k]   = ld_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q    <= '0;
      wreg_q <= '0;
      ld_q   <= '0;
      rn_q   <= '0;
    end else begin
      v_q    <= v_d;
      wreg_q <= wreg_d;
      ld_q   <= ld_d;
      rn_q   <= rn_d;
    end
  end

`ifdef PIPEID_SB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (id_valid && !nostall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (id_valid && nostall && ((fwda != '0) || (fwdb != '0)) && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeid_hazard_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeid_hazard_sb : vector-table bench for pipeid_hazard_sb               |
// | (DEPTH=3, LD_STAGE=1). Revision: 1.0                                        |
// +----------------------------------------------------------------------------+
module tb_pipeid_hazard_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int DEPTH = 3;
  localparam int SW   = 2;
  localparam int NV   = 20;

  logic                  clk = 1'b0;
  logic                  clrn;
  logic                  id_valid;
  logic [AW-1:0]         id_rs, id_rt, id_rn;
  logic                  id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
  logic [XLEN-1:0]       rf_qa, rf_qb;
  logic [DEPTH*XLEN-1:0] stage_res;
  logic [XLEN-1:0]       a, b;
  logic [SW-1:0]         fwda, fwdb;
  logic                  nostall;
`ifdef PIPEID_SB_STATS_EN
  logic [31:0]           stall_cnt, fwd_cnt;
`endif

  pipeid_hazard_sb #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LD_STAGE(1), .SW(SW)) dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
    .id_m2reg(id_m2reg), .flush(flush), .rf_qa(rf_qa), .rf_qb(rf_qb),
    .stage_res(stage_res), .a(a), .b(b), .fwda(fwda), .fwdb(fwdb),
`ifdef PIPEID_SB_STATS_EN
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .nostall(nostall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [AW-1:0] rs, rt; logic urs, urt, wr; logic [AW-1:0] rn; logic ld, fl;
    logic [SW-1:0] efa, efb; logic ens; logic chk;
  } vec_t;

  typedef struct {
    string tag; logic [SW-1:0] fa, fb; logic ns; logic chk; logic [XLEN-1:0] ea, eb;
  } exp_t;

  localparam logic [XLEN-1:0] RFA = 32'hAAAA_AAAA;
  localparam logic [XLEN-1:0] RFB = 32'hBBBB_BBBB;
  logic [XLEN-1:0] st [DEPTH];

  vec_t tbl [NV];
  exp_t sbq [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                              input logic urt, input logic wr, input int rn, input logic ld,
                              input logic fl, input int efa, input int efb, input logic ens,
                              input logic chk);
    vec_t t;
    t.v = v; t.rs = AW'(rs); t.rt = AW'(rt); t.urs = urs; t.urt = urt; t.wr = wr;
    t.rn = AW'(rn); t.ld = ld; t.fl = fl; t.efa = SW'(efa); t.efb = SW'(efb);
    t.ens = ens; t.chk = chk;
    return t;
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic [SW-1:0] sel, input logic [XLEN-1:0] rf);
    if (sel == '0) return rf;
    return st[int'(sel) - 1];
  endfunction

  task automatic cmp(input string tag, input string what, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %h, want %h", tag, what, got, want);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_wreg = t.wr; id_rn = t.rn; id_m2reg = t.ld; flush = t.fl;
    e.tag = tag; e.fa = t.efa; e.fb = t.efb; e.ns = t.ens; e.chk = t.chk;
    e.ea = pick(t.efa, RFA); e.eb = pick(t.efb, RFB);
    sbq.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard: got empty queue, want an entry");
      return;
    end
    e = sbq.pop_front();
    cmp(e.tag, "nostall", XLEN'(nostall), XLEN'(e.ns));
    if (e.chk) begin
      cmp(e.tag, "fwda", XLEN'(fwda), XLEN'(e.fa));
      cmp(e.tag, "fwdb", XLEN'(fwdb), XLEN'(e.fb));
      cmp(e.tag, "a", a, e.ea);
      cmp(e.tag, "b", b, e.eb);
    end
  endtask

  initial begin
    st[0] = 32'h0000_1234; st[1] = 32'h5555_0001; st[2] = 32'h6666_0002;
    stage_res = {st[2], st[1], st[0]};
    rf_qa = RFA; rf_qb = RFB;
    clrn = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_rn = 0; id_m2reg = 0; flush = 0;

    //            v rs rt urs urt wr rn ld fl fa fb ns chk
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 1, 1); // add r3
    tbl[1]  = mk(1, 3, 0, 1, 1, 1, 5, 0, 0, 1, 0, 1, 1); // ALU dep on r3
    tbl[2]  = mk(1, 3, 2, 0, 1, 1, 6, 0, 0, 0, 0, 1, 1); // rs unused
    tbl[3]  = mk(1, 8, 9, 1, 1, 1, 10, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 11, 5, 1, 1, 0, 0, 0, 0, 0, 3, 1, 1); // distance 3
    tbl[5]  = mk(1, 6, 10, 1, 1, 1, 4, 1, 0, 3, 2, 1, 1); // lw r4
    tbl[6]  = mk(1, 4, 10, 1, 1, 1, 12, 0, 0, 1, 3, 0, 1); // load-use stall
    tbl[7]  = mk(1, 4, 10, 1, 1, 1, 12, 0, 0, 2, 0, 1, 1); // retry
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 1);
    tbl[9]  = mk(1, 12, 0, 1, 1, 1, 13, 0, 0, 2, 0, 1, 1);
    tbl[10] = mk(1, 12, 13, 1, 1, 1, 7, 0, 0, 3, 1, 1, 1);
    tbl[11] = mk(1, 7, 7, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1); // youngest wins; dest r0
    tbl[12] = mk(1, 0, 0, 1, 1, 1, 9, 0, 1, 0, 0, 1, 1); // flushed r9
    tbl[13] = mk(1, 9, 7, 1, 1, 1, 14, 1, 0, 0, 3, 1, 1);
    tbl[14] = mk(1, 14, 0, 1, 0, 1, 15, 0, 1, 1, 0, 0, 1); // stall despite flush
    tbl[15] = mk(0, 14, 0, 1, 0, 1, 16, 0, 0, 0, 0, 1, 0); // invalid: no stall
    tbl[16] = mk(1, 14, 0, 1, 0, 1, 14, 0, 0, 3, 0, 1, 1);
    tbl[17] = mk(1, 14, 0, 1, 0, 1, 14, 1, 0, 1, 0, 1, 1);
    tbl[18] = mk(1, 14, 14, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1); // youngest is load
    tbl[19] = mk(1, 14, 0, 1, 0, 1, 2, 0, 0, 2, 0, 1, 1); // issues r2

    @(negedge clk);
    apply(mk(1, 3, 3, 1, 1, 1, 3, 0, 0, 0, 0, 1, 1), "in_reset");
    #2 sample();
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tbl[i], $sformatf("row%0d", i));
      #2 sample();
    end

    @(negedge clk);
    clrn = 1'b0;
    apply(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "mid_reset");
    #2 sample();
    @(negedge clk);
    clrn = 1'b1;
    apply(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "post_reset");
    #2 sample();
`ifdef PIPEID_SB_STATS_EN
    cmp("post_reset", "stall_cnt", stall_cnt, 32'd0);
    cmp("post_reset", "fwd_cnt", fwd_cnt, 32'd0);
`endif

    if (sbq.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard drain: got %0d left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
